// File: rtl/math_cmd_dispatch.sv
// Command front-end for the LUT math engine: buffers element-wise commands,
// drops zero-length/illegal ones, and feeds the engine one chunk at a time.
module math_cmd_dispatch #(
    parameter int DEPTH     = 4,
    parameter int MAX_CHUNK = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_opcode,
    input  logic [15:0] in_src_base,
    input  logic [15:0] in_dst_base,
    input  logic [15:0] in_length,
    output logic        me_cmd_valid,
    output logic [7:0]  me_cmd_opcode,
    output logic [15:0] me_cmd_src_base,
    output logic [15:0] me_cmd_dst_base,
    output logic [15:0] me_cmd_length,
    input  logic        me_busy,
    input  logic        me_done,
    output logic        cmd_done,
    output logic        err_opcode,
    output logic [15:0] done_count,
    output logic        idle
);
    localparam logic [7:0] OP_G_EXP   = 8'h30;
    localparam logic [7:0] OP_G_LOG   = 8'h31;
    localparam logic [7:0] OP_G_SQRT  = 8'h32;
    localparam logic [7:0] OP_G_RSQRT = 8'h33;

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [15:0] MAX_CHUNK_W = 16'(MAX_CHUNK);

    typedef enum logic [1:0] {D_IDLE, D_ISSUE, D_WAIT, D_FIN} state_e;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
    } cmd_t;

    cmd_t          fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    state_e        state_q, state_d;
    logic [7:0]    op_q, op_d;
    logic [15:0]   src_q, src_d, dst_q, dst_d, rem_q, rem_d;
    logic          zl_done_q, err_q;
    logic [15:0]   done_count_q, done_count_d;

    logic          legal, xfer, push, pop, issue, fin;
    logic [15:0]   chunk;
    cmd_t          in_cmd;

    assign legal    = (in_opcode == OP_G_EXP) || (in_opcode == OP_G_LOG) ||
                      (in_opcode == OP_G_SQRT) || (in_opcode == OP_G_RSQRT);
    assign in_ready = (count_q < DEPTH_W);
    assign xfer     = in_valid && in_ready;
    assign push     = xfer && legal && (in_length != 16'd0);
    assign in_cmd   = '{op: in_opcode, src: in_src_base, dst: in_dst_base, len: in_length};
    assign chunk    = (rem_q > MAX_CHUNK_W) ? MAX_CHUNK_W : rem_q;
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        pop     = 1'b0;
        issue   = 1'b0;
        fin     = 1'b0;
        case (state_q)
            D_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    op_d    = fifo_q[rd_ptr_q].op;
                    src_d   = fifo_q[rd_ptr_q].src;
                    dst_d   = fifo_q[rd_ptr_q].dst;
                    rem_d   = fifo_q[rd_ptr_q].len;
                    state_d = D_ISSUE;
                end
            end
            D_ISSUE: begin
                if (!me_busy) begin
                    issue   = 1'b1;
                    src_d   = src_q + chunk;
                    dst_d   = dst_q + chunk;
                    rem_d   = rem_q - chunk;
                    state_d = D_WAIT;
                end
            end
            D_WAIT: begin
                if (me_done) state_d = (rem_q == 16'd0) ? D_FIN : D_ISSUE;
            end
            D_FIN: begin
                fin     = 1'b1;
                state_d = D_IDLE;
            end
            default: state_d = D_IDLE;
        endcase
    end

    // A zero-length completion and an FSM completion can land together.
    assign done_count_d = done_count_q + 16'(fin) + 16'(zl_done_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            state_q      <= D_IDLE;
            op_q         <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            rem_q        <= '0;
            zl_done_q    <= 1'b0;
            err_q        <= 1'b0;
            done_count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= in_cmd;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q      <= count_d;
            state_q      <= state_d;
            op_q         <= op_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            rem_q        <= rem_d;
            zl_done_q    <= xfer && legal && (in_length == 16'd0);
            err_q        <= xfer && !legal;
            done_count_q <= done_count_d;
        end
    end

    assign me_cmd_valid    = issue;
    assign me_cmd_opcode   = (state_q == D_ISSUE) ? op_q  : 8'd0;
    assign me_cmd_src_base = (state_q == D_ISSUE) ? src_q : 16'd0;
    assign me_cmd_dst_base = (state_q == D_ISSUE) ? dst_q : 16'd0;
    assign me_cmd_length   = (state_q == D_ISSUE) ? chunk : 16'd0;
    assign cmd_done        = fin || zl_done_q;
    assign err_opcode      = err_q;
    assign done_count      = done_count_q;
    assign idle            = (count_q == '0) && (state_q == D_IDLE) && !me_busy;

endmodule

// File: tb/tb_math_cmd_dispatch.sv
// Randomized bench for math_cmd_dispatch with a chunk-list reference model
// and a small behavioural engine responder.
module tb_math_cmd_dispatch;
    localparam int DEPTH     = 4;
    localparam int MAX_CHUNK = 256;
    localparam logic [7:0] OP_EXP = 8'h30, OP_LOG = 8'h31, OP_SQRT = 8'h32, OP_RSQRT = 8'h33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_opcode = '0;
    logic [15:0] in_src_base = '0, in_dst_base = '0, in_length = '0;
    logic        me_cmd_valid;
    logic [7:0]  me_cmd_opcode;
    logic [15:0] me_cmd_src_base, me_cmd_dst_base, me_cmd_length;
    logic        me_busy = 1'b0, me_done = 1'b0;
    logic        cmd_done, err_opcode, idle;
    logic [15:0] done_count;

    math_cmd_dispatch #(.DEPTH(DEPTH), .MAX_CHUNK(MAX_CHUNK)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
        .in_src_base(in_src_base), .in_dst_base(in_dst_base), .in_length(in_length),
        .me_cmd_valid(me_cmd_valid), .me_cmd_opcode(me_cmd_opcode),
        .me_cmd_src_base(me_cmd_src_base), .me_cmd_dst_base(me_cmd_dst_base),
        .me_cmd_length(me_cmd_length), .me_busy(me_busy), .me_done(me_done),
        .cmd_done(cmd_done), .err_opcode(err_opcode), .done_count(done_count), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  op;
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
    } chunk_t;

    chunk_t exp_q[$];
    int     n_checks = 0, n_errors = 0;
    int     cyc = 0;
    int     exp_done = 0, exp_errpulse = 0;
    int     n_issue = 0, n_cmd_done = 0, n_errpulse = 0;
    int     accept_cyc = 0, last_issue_cyc = 0, last_me_done_cyc = 0, last_cmd_done_cyc = 0;
    bit     eng_out = 0, eng_hold = 0, force_busy = 0, noise_en = 0, stray_req = 0;
    int     eng_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [7:0] op);
        return op == OP_EXP || op == OP_LOG || op == OP_SQRT || op == OP_RSQRT;
    endfunction

    // Reference: every accepted legal command becomes an ordered list of chunks.
    task automatic model_accept(input logic [7:0] op, input logic [15:0] src,
                                input logic [15:0] dst, input logic [15:0] len);
        int r, c;
        logic [15:0] s, d;
        if (!is_legal(op)) begin
            exp_errpulse++;
        end else begin
            exp_done++;
            r = len; s = src; d = dst;
            while (r > 0) begin
                c = (r > MAX_CHUNK) ? MAX_CHUNK : r;
                exp_q.push_back('{op: op, src: s, dst: d, len: 16'(c)});
                s = s + 16'(c);
                d = d + 16'(c);
                r = r - c;
            end
        end
    endtask

    // Monitor and engine responder: sample on negedge, drive just after posedge.
    initial begin
        chunk_t c;
        logic nb, nd;
        forever begin
            @(negedge clk);
            nb = 1'b0; nd = 1'b0;
            if (!rst_n) begin
                eng_out = 0;
            end else begin
                if (me_cmd_valid) begin
                    n_issue++;
                    last_issue_cyc = cyc;
                    check("valid_while_busy", me_busy, 0);
                    check("issue_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        c = exp_q.pop_front();
                        check("iss_op", me_cmd_opcode, c.op);
                        check("iss_src", me_cmd_src_base, c.src);
                        check("iss_dst", me_cmd_dst_base, c.dst);
                        check("iss_len", me_cmd_length, c.len);
                    end
                    eng_out = 1;
                    eng_cnt = $urandom_range(1, 4);
                end
                if (cmd_done) begin n_cmd_done++; last_cmd_done_cyc = cyc; end
                if (err_opcode) n_errpulse++;
                if (me_done) last_me_done_cyc = cyc;
                if (eng_out) begin
                    if (!eng_hold) begin
                        if (eng_cnt == 0) begin nd = 1'b1; eng_out = 0; end
                        else eng_cnt--;
                    end
                    if (eng_out) nb = 1'b1;
                end else begin
                    nb = force_busy || (noise_en && $urandom_range(0, 3) == 0);
                    if (stray_req) begin nd = 1'b1; stray_req = 0; end
                end
            end
            @(posedge clk);
            #1;
            me_busy = nb;
            me_done = nd;
        end
    end

    // Called at posedge+2; returns at posedge+2 with in_valid low.
    task automatic send(input logic [7:0] op, input logic [15:0] src,
                        input logic [15:0] dst, input logic [15:0] len);
        bit ok = 0;
        in_valid = 1'b1; in_opcode = op; in_src_base = src; in_dst_base = dst; in_length = len;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1; break; end
        end
        check("accept_in_time", ok, 1);
        if (ok) begin
            accept_cyc = cyc;
            model_accept(op, src, dst, len);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (idle && exp_q.size() == 0 && !eng_out && !in_valid) begin ok = 1; break; end
        end
        check("drain_in_time", ok, 1);
        repeat (3) @(posedge clk);
        #2;
    endtask

    initial begin
        int b_issue, b_done, b_err, g, sel;
        logic [7:0] op;
        logic [15:0] len;
        logic [7:0] ops [4];
        bit ok;
        ops[0] = OP_EXP; ops[1] = OP_LOG; ops[2] = OP_SQRT; ops[3] = OP_RSQRT;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_idle", idle, 1);
        check("rst_valid", me_cmd_valid, 0);
        check("rst_done_count", done_count, 0);
        check("rst_cmd_done", cmd_done, 0);
        check("rst_err", err_opcode, 0);
        check("rst_len", me_cmd_length, 0);
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #2;

        // Single EXP command, latency
        send(OP_EXP, 16'h0100, 16'h0200, 16'd10);
        drain();
        check("t1_issue_latency", last_issue_cyc - accept_cyc, 2);
        check("t1_done_latency", last_cmd_done_cyc - last_me_done_cyc, 1);
        check("t1_done_count", done_count, 16'(exp_done));
        check("t1_done_count_abs", done_count, 1);

        // Long SQRT split into chunks
        b_issue = n_issue; b_done = n_cmd_done;
        send(OP_SQRT, 16'h0000, 16'h1000, 16'd600);
        drain();
        check("t2_issues", n_issue - b_issue, 3);
        check("t2_cmd_done", n_cmd_done - b_done, 1);
        check("t2_done_count", done_count, 2);

        // Illegal opcode and zero-length
        b_issue = n_issue; b_done = n_cmd_done; b_err = n_errpulse;
        send(8'hFF, 16'h0010, 16'h0020, 16'd5);
        send(OP_LOG, 16'h0030, 16'h0040, 16'd0);
        drain();
        check("t3_err_pulses", n_errpulse - b_err, 1);
        check("t3_issues", n_issue - b_issue, 0);
        check("t3_cmd_done", n_cmd_done - b_done, 1);
        check("t3_done_count", done_count, 3);

        // Stalled engine fills the FIFO
        eng_hold = 1;
        for (int i = 0; i < 5; i++) send(ops[i % 4], 16'(i * 16), 16'(16'h8000 + i * 16), 16'd3);
        @(negedge clk);
        check("t4_in_ready_full", in_ready, 0);
        @(posedge clk); #2;
        eng_hold = 0;
        drain();
        check("t4_done_count", done_count, 8);

        // Engine busy holds off the issue; stray done while idle
        force_busy = 1;
        @(posedge clk); #2;
        b_issue = n_issue;
        send(OP_RSQRT, 16'hFFFE, 16'h7FFE, 16'd4);
        repeat (6) @(posedge clk);
        #2;
        check("t5_no_issue_busy", n_issue - b_issue, 0);
        force_busy = 0;
        drain();
        check("t5_one_issue", n_issue - b_issue, 1);
        check("t5_done_count", done_count, 9);
        stray_req = 1;
        repeat (4) @(posedge clk);
        #2;
        check("t5_stray_done_count", done_count, 9);
        check("t5_stray_issue", n_issue - b_issue, 1);
        check("t5_stray_idle", idle, 1);

        // Reset while waiting on the engine with two queued
        eng_hold = 1;
        b_issue = n_issue;
        for (int i = 0; i < 3; i++) send(OP_EXP, 16'(i * 32), 16'(i * 32), 16'd5);
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (n_issue != b_issue) begin ok = 1; break; end
        end
        check("t6_reached_wait", ok, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("t6_valid", me_cmd_valid, 0);
        check("t6_cmd_done", cmd_done, 0);
        check("t6_err", err_opcode, 0);
        check("t6_done_count", done_count, 0);
        check("t6_in_ready", in_ready, 1);
        check("t6_src", me_cmd_src_base, 0);
        exp_q.delete();
        exp_done = 0;
        eng_hold = 0;
        repeat (2) @(posedge clk);
        #2;
        check("t6_idle", idle, 1);
        b_done = n_cmd_done;
        @(posedge clk); #3;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        check("t6_no_cmd_done", n_cmd_done - b_done, 0);
        check("t6_done_count_after", done_count, 0);

        // Randomized traffic
        noise_en = 1;
        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 8) ? ops[$urandom_range(0, 3)] : 8'($urandom);
            sel = $urandom_range(0, 9);
            if (sel == 0) len = 16'd0;
            else if (sel < 8) len = 16'($urandom_range(1, 20));
            else len = 16'($urandom_range(200, 700));
            send(op, 16'($urandom), 16'($urandom), len);
            g = $urandom_range(0, 2);
            repeat (g) @(posedge clk);
            if (g != 0) #2;
        end
        noise_en = 0;
        drain();
        check("rand_done_count", done_count, 16'(exp_done));
        check("rand_err_pulses", n_errpulse, exp_errpulse);
        check("rand_queue_empty", exp_q.size(), 0);
        check("rand_idle", idle, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
